// File: rtl/inst_queue.sv
// inst_queue: decoupling queue between fetch and decode.
//
// Takes a bundle of up to IN_W instructions per cycle with an arbitrary lane
// valid mask. Only the valid lanes are stored, packed in ascending lane order.
// Up to OUT_W of the oldest entries are shown to decode, which consumes a
// variable number of them through deq_num_i. Storage is a DEPTH-entry circular
// buffer with an exact occupancy count and a flush.
//
// Optional feature: define INST_QUEUE_PC_EN to store a 64-bit PC with every
// entry. This adds the in_pc_i and out_pc_o ports.
//
// Ports:
//   clock            sole clock, rising edge
//   reset            synchronous active-high reset (clears pointers and count)
//   flush_i          discard all contents; same-cycle push/dequeue are dropped
//   in_bundle_vld_i  bundle present this cycle
//   in_vld_i         per-lane valid, lane k = bit k, may be sparse
//   in_inst_i        lane k at [k*IW +: IW]
//   in_pc_i          (PC_EN) PC of bundle lane 0
//   in_rdy_o         room for a full bundle (ignores same-cycle dequeue)
//   out_inst_o       oldest entries, lane 0 = oldest; invalid lanes are 0
//   out_vld_o        thermometer valid mask from lane 0
//   out_pc_o         (PC_EN) PC per output lane; invalid lanes are 0
//   deq_num_i        entries consumed this cycle; clamped to the valid count
//   count_o          current occupancy
//   full_o / empty_o occupancy == DEPTH / occupancy == 0
module inst_queue #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 4,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IW    = 32,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned DNW  = $clog2(OUT_W + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               in_bundle_vld_i,
  input  logic [IN_W-1:0]    in_vld_i,
  input  logic [IN_W*IW-1:0] in_inst_i,
`ifdef INST_QUEUE_PC_EN
  input  logic [63:0]        in_pc_i,
  output logic [OUT_W*64-1:0] out_pc_o,
`endif
  output logic               in_rdy_o,
  output logic [OUT_W*IW-1:0] out_inst_o,
  output logic [OUT_W-1:0]   out_vld_o,
  input  logic [DNW-1:0]     deq_num_i,
  output logic [CW-1:0]      count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(IN_W + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [IW-1:0] mem_q [DEPTH];
`ifdef INST_QUEUE_PC_EN
  logic [63:0]   pc_mem_q [DEPTH];
`endif

  logic          push;
  logic [NW-1:0] n_in;
  logic [NW-1:0] n_push;
  logic [NW-1:0] lane_off [IN_W];
  logic [CW-1:0] avail;
  logic [CW-1:0] deq;

  assign in_rdy_o = (CW'(DEPTH) - count_q) >= CW'(IN_W);
  assign push     = in_bundle_vld_i & in_rdy_o & ~flush_i;

  // Each valid lane's slot offset = number of valid lanes below it.
  always_comb begin
    n_in = '0;
    for (int k = 0; k < IN_W; k++) begin
      lane_off[k] = n_in;
      if (in_vld_i[k]) n_in = n_in + NW'(1);
    end
  end

  assign n_push = push ? n_in : '0;

  // Entries visible to decode; an over-large deq_num_i is clamped to this.
  assign avail = (count_q < CW'(OUT_W)) ? count_q : CW'(OUT_W);

  always_comb begin
    deq = '0;
    if (!flush_i) deq = (CW'(deq_num_i) > avail) ? avail : CW'(deq_num_i);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(n_push);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    count_d  = count_q + CW'(n_push) - deq;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; pointers alone define what is live.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int k = 0; k < IN_W; k++) begin
        if (in_vld_i[k]) begin
          mem_q[wr_ptr_q + PW'(lane_off[k])] <= in_inst_i[k*IW +: IW];
`ifdef INST_QUEUE_PC_EN
          // PC comes from the original lane position, before packing.
          pc_mem_q[wr_ptr_q + PW'(lane_off[k])] <= in_pc_i + 64'(4 * k);
`endif
        end
      end
    end
  end

  always_comb begin
    out_inst_o = '0;
    out_vld_o  = '0;
`ifdef INST_QUEUE_PC_EN
    out_pc_o   = '0;
`endif
    for (int k = 0; k < OUT_W; k++) begin
      if (CW'(k) < avail) begin
        out_vld_o[k]            = 1'b1;
        out_inst_o[k*IW +: IW]  = mem_q[rd_ptr_q + PW'(k)];
`ifdef INST_QUEUE_PC_EN
        out_pc_o[k*64 +: 64]    = pc_mem_q[rd_ptr_q + PW'(k)];
`endif
      end
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with its default parameters
// (IN_W=8, OUT_W=4, DEPTH=32, IW=32).
module tb_inst_queue;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 4;
  localparam int unsigned IW    = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic                flush_i;
  logic                in_bundle_vld_i;
  logic [IN_W-1:0]     in_vld_i;
  logic [IN_W*IW-1:0]  in_inst_i;
  logic [63:0]         in_pc_i;
  logic [OUT_W*64-1:0] out_pc_o;
  logic                in_rdy_o;
  logic [OUT_W*IW-1:0] out_inst_o;
  logic [OUT_W-1:0]    out_vld_o;
  logic [2:0]          deq_num_i;
  logic [5:0]          count_o;
  logic                full_o;
  logic                empty_o;

  int errors = 0;
  int checks = 0;

  inst_queue dut (
    .clock           (clock),
    .reset           (reset),
    .flush_i         (flush_i),
    .in_bundle_vld_i (in_bundle_vld_i),
    .in_vld_i        (in_vld_i),
    .in_inst_i       (in_inst_i),
`ifdef INST_QUEUE_PC_EN
    .in_pc_i         (in_pc_i),
    .out_pc_o        (out_pc_o),
`endif
    .in_rdy_o        (in_rdy_o),
    .out_inst_o      (out_inst_o),
    .out_vld_o       (out_vld_o),
    .deq_num_i       (deq_num_i),
    .count_o         (count_o),
    .full_o          (full_o),
    .empty_o         (empty_o)
  );

`ifndef INST_QUEUE_PC_EN
  assign out_pc_o = '0;
`endif

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Lane k carries base + k; one cycle with the bundle offered.
  task automatic push(input logic [7:0] mask, input logic [31:0] base);
    in_bundle_vld_i = 1'b1;
    in_vld_i        = mask;
    for (int k = 0; k < IN_W; k++) in_inst_i[k*IW +: IW] = base + 32'(k);
    cyc();
    in_bundle_vld_i = 1'b0;
    in_vld_i        = '0;
  endtask

  task automatic deq(input logic [2:0] n);
    deq_num_i = n;
    cyc();
    deq_num_i = '0;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; in_bundle_vld_i = 1'b0; in_vld_i = '0;
    in_inst_i = '0; in_pc_i = '0; deq_num_i = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_rdy", in_rdy_o, 1);
    chk("rst_vld", out_vld_o, 4'b0000);
    chk("rst_inst", out_inst_o, 0);

    // Full bundle
    push(8'hFF, 32'h100);
    chk("full_vld", out_vld_o, 4'b1111);
    chk("full_count", count_o, 8);
    chk("full_inst", out_inst_o, lanes(32'h100, 32'h101, 32'h102, 32'h103));
    deq(4);
    chk("deq4_count", count_o, 4);
    chk("deq4_inst", out_inst_o, lanes(32'h104, 32'h105, 32'h106, 32'h107));
    deq(4);
    chk("drain_empty", empty_o, 1);

    // Sparse mask compaction
    push(8'b1010_0101, 32'hA0);
    chk("sparse_count", count_o, 4);
    chk("sparse_inst", out_inst_o, lanes(32'hA0, 32'hA2, 32'hA5, 32'hA7));
    deq(4);
    chk("sparse_drain", count_o, 0);

    // Fill to 25 -> not ready
    push(8'hFF, 32'h200);
    push(8'hFF, 32'h210);
    push(8'hFF, 32'h220);
    chk("fill24_rdy", in_rdy_o, 1);
    push(8'h01, 32'h230);
    chk("fill25_count", count_o, 25);
    chk("fill25_rdy", in_rdy_o, 0);
    push(8'hFF, 32'hEE0);
    chk("ignored_count", count_o, 25);
    deq(1);
    chk("deq1_count", count_o, 24);
    chk("deq1_rdy", in_rdy_o, 1);
    chk("deq1_inst", out_inst_o, lanes(32'h201, 32'h202, 32'h203, 32'h204));
    push(8'hFF, 32'h240);
    chk("full32_count", count_o, 32);
    chk("full32_full", full_o, 1);
    chk("full32_rdy", in_rdy_o, 0);
    for (int i = 0; i < 6; i++) deq(4);
    chk("drain24_inst", out_inst_o, lanes(32'h240, 32'h241, 32'h242, 32'h243));
    deq(4); deq(4);
    chk("drain32_empty", empty_o, 1);

    // Move pointers to 28 (currently 13): push 15, drain 15
    push(8'hFF, 32'h400);
    push(8'h7F, 32'h410);
    chk("pre_wrap_count", count_o, 15);
    deq(4); deq(4); deq(4); deq(3);
    chk("pre_wrap_empty", empty_o, 1);

    // Wrap-around: entries land at 28..31 and 0..3
    push(8'hFF, 32'h300);
    chk("wrap_count", count_o, 8);
    chk("wrap_inst0", out_inst_o, lanes(32'h300, 32'h301, 32'h302, 32'h303));
    deq(4);
    chk("wrap_inst1", out_inst_o, lanes(32'h304, 32'h305, 32'h306, 32'h307));
    deq(4);
    chk("wrap_empty", empty_o, 1);

    // Partial valid lanes and clamped dequeue
    push(8'h03, 32'h50);
    chk("part_vld", out_vld_o, 4'b0011);
    chk("part_inst", out_inst_o, lanes(32'h50, 32'h51, 32'h0, 32'h0));
    deq(4);
    chk("clamp_count", count_o, 0);

    // Empty bundle is a no-op
    push(8'h00, 32'h0);
    chk("nomask_count", count_o, 0);

    // Simultaneous push and dequeue
    push(8'hFF, 32'h600);
    deq_num_i = 3'd3;
    push(8'hFF, 32'h610);
    deq_num_i = '0;
    chk("pushdeq_count", count_o, 13);
    chk("pushdeq_inst", out_inst_o, lanes(32'h603, 32'h604, 32'h605, 32'h606));
    deq(1);
    chk("preflush_count", count_o, 12);

    // Flush with simultaneous push and dequeue
    flush_i = 1'b1;
    deq_num_i = 3'd4;
    push(8'hFF, 32'h800);
    flush_i = 1'b0;
    deq_num_i = '0;
    chk("flush_count", count_o, 0);
    chk("flush_empty", empty_o, 1);
    chk("flush_vld", out_vld_o, 4'b0000);
    chk("flush_inst", out_inst_o, 0);
    in_pc_i = 64'h1000;
    push(8'h07, 32'h700);
    chk("postflush_vld", out_vld_o, 4'b0111);
    chk("postflush_inst", out_inst_o, lanes(32'h700, 32'h701, 32'h702, 32'h0));
`ifdef INST_QUEUE_PC_EN
    chk("postflush_pc", out_pc_o, {64'h0, 64'h1008, 64'h1004, 64'h1000});
    deq(3);
    // PC follows the original lane index, not the packed slot
    in_pc_i = 64'h2000;
    push(8'b1000_0010, 32'h900);
    chk("sparse_pc", out_pc_o, {64'h0, 64'h0, 64'h201C, 64'h2004});
`endif

    // Reset mid-stream
    push(8'hFF, 32'hB00);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_count", count_o, 0);
    chk("midrst_empty", empty_o, 1);
    chk("midrst_rdy", in_rdy_o, 1);
    chk("midrst_vld", out_vld_o, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
